// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, state encoding and
// control-word bit positions.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    StT1   = 3'd0,
    StT2   = 3'd1,
    StT3   = 3'd2,
    StT4   = 3'd3,
    StT5   = 3'd4,
    StT6   = 3'd5,
    StHalt = 3'd6
  } state_e;

  localparam int unsigned CW_PC_SEND  = 0;
  localparam int unsigned CW_PC_INC   = 1;
  localparam int unsigned CW_MAR_LOAD = 2;
  localparam int unsigned CW_RAM_SEND = 3;
  localparam int unsigned CW_IR_LOAD  = 4;
  localparam int unsigned CW_IR_SEND  = 5;
  localparam int unsigned CW_A_LOAD   = 6;
  localparam int unsigned CW_A_SEND   = 7;
  localparam int unsigned CW_B_LOAD   = 8;
  localparam int unsigned CW_ALU_SEND = 9;
  localparam int unsigned CW_ALU_SUB  = 10;
  localparam int unsigned CW_OUT_LOAD = 11;
  localparam int unsigned CW_W        = 12;

  // Map the one-hot ring plus halt flag onto the symbolic state.
  function automatic state_e onehot_to_state(logic [5:0] ring, logic halt);
    state_e s;
    s = StT1;
    for (int i = 0; i < 6; i++) begin
      if (ring[i]) s = state_e'(3'(i));
    end
    if (halt) s = StHalt;
    return s;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring counter with enable and synchronous clear back to T1.
module ring_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] t_state
);

  logic [Width-1:0] ring_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q <= Width'(1);
    end else if (clr) begin
      ring_q <= Width'(1);
    end else if (en) begin
      ring_q <= {ring_q[Width-2:0], ring_q[Width-1]};
    end
  end

  assign t_state = ring_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: decodes T-state and opcode into bus strobes.
// Define SHORT_CYCLE_EN to skip execute states that carry no strobes.
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned T_STATES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OP_W-1:0]     opcode,
  output logic                pc_send,
  output logic                pc_inc,
  output logic                mar_load,
  output logic                ram_send,
  output logic                ir_load,
  output logic                ir_send,
  output logic                a_load,
  output logic                a_send,
  output logic                b_load,
  output logic                alu_send,
  output logic                alu_sub,
  output logic                out_load,
  output logic                halted,
  output logic [T_STATES-1:0] t_state
);

  if (T_STATES != 6) begin : gen_t_states_check
    $error("controller_sequencer: T_STATES must be 6");
  end

  logic [T_STATES-1:0] ring;
  logic                halt_q, halt_d;
  logic                hlt_now;
  logic                ring_en, ring_clr;
  logic [CW_W-1:0]     cw;
  state_e              state;

  assign state   = onehot_to_state(ring, halt_q);
  assign hlt_now = run && (state == StT4) && (opcode == OP_HLT);
  assign halt_d  = halt_q | hlt_now;
  assign ring_en = run & ~halt_q & ~hlt_now;

`ifdef SHORT_CYCLE_EN
  // Jump back to T1 from the last execute state that actually does something.
  assign ring_clr = run && !halt_q &&
                    (((state == StT5) && (opcode == OP_LDA)) ||
                     ((state == StT4) && !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT})));
`else
  assign ring_clr = 1'b0;
`endif

  ring_counter #(
    .Width(T_STATES)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .en     (ring_en),
    .clr    (ring_clr),
    .t_state(ring)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  always_comb begin
    cw = '0;
    unique case (state)
      StT1: begin
        cw[CW_PC_SEND]  = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      StT2: cw[CW_PC_INC] = 1'b1;
      StT3: begin
        cw[CW_RAM_SEND] = 1'b1;
        cw[CW_IR_LOAD]  = 1'b1;
      end
      StT4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_IR_SEND]  = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_SEND]   = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_SEND] = 1'b1;
            cw[CW_A_LOAD]   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_SEND] = 1'b1;
            cw[CW_B_LOAD]   = 1'b1;
          end
          default: ;
        endcase
      end
      StT6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_SEND] = 1'b1;
          cw[CW_A_LOAD]   = 1'b1;
          cw[CW_ALU_SUB]  = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
    // Paused or in reset: nothing may act on the bus.
    if (!(rst && run)) cw = '0;
  end

  assign pc_send  = cw[CW_PC_SEND];
  assign pc_inc   = cw[CW_PC_INC];
  assign mar_load = cw[CW_MAR_LOAD];
  assign ram_send = cw[CW_RAM_SEND];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_send  = cw[CW_IR_SEND];
  assign a_load   = cw[CW_A_LOAD];
  assign a_send   = cw[CW_A_SEND];
  assign b_load   = cw[CW_B_LOAD];
  assign alu_send = cw[CW_ALU_SEND];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign out_load = cw[CW_OUT_LOAD];
  assign halted   = halt_q;
  assign t_state  = halt_q ? '0 : ring;

endmodule
